// File: rtl/clk_edge_meter_pkg.sv
// Shared definitions for the slow-clock edge meter.
// Holds the meter FSM encoding and default widths.
package clk_edge_meter_pkg;

  localparam int CNT_W       = 27;
  localparam int TIMEOUT_DEF = 100000000;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    VALID      = 2'd2
  } meter_st_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop for a slow async input.
// Produces one-cycle rise/fall strobes and the synchronized level.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall,
  output logic o_level
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_v1;
  logic r_v2;
  logic r_armed;

  // A rise only counts once a genuine low has been sampled after reset,
  // so an input already high at release cannot fake a rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= i_d;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_v1    <= 1'b1;
      r_v2    <= r_v1;
      r_armed <= r_armed | (r_v2 & ~r_s2);
    end
  end

  assign o_rise  = r_s2 & ~r_s3 & r_armed;
  assign o_fall  = ~r_s2 & r_s3;
  assign o_level = r_s2;

endmodule

// File: rtl/clk_edge_meter.sv
// Measures period and high time of a slow square wave in Clk cycles.
// Flags loss of the slow clock after TimeoutVal cycles without a rise.
module clk_edge_meter
  import clk_edge_meter_pkg::*;
#(
  parameter int TimeoutVal = TIMEOUT_DEF,
  parameter int CntW       = CNT_W
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            SlowIn,
  output logic            Tick,
  output logic [CntW-1:0] Period,
  output logic [CntW-1:0] HighTime,
  output logic            PeriodValid,
  output logic            Timeout
);

  localparam logic [CntW-1:0] TO  = CntW'(TimeoutVal);
  localparam logic [CntW-1:0] ONE = CntW'(1);

  logic            w_rise;
  logic            w_fall;
  logic            w_level;
  logic            w_per_sat;
  logic            w_cap_per;
  logic            w_cap_hi;
  logic            w_to_hit;
  logic [CntW-1:0] w_per_inc;
  logic [CntW-1:0] w_hi_inc;
  meter_st_e       r_state;
  meter_st_e       w_state_nxt;
  logic [CntW-1:0] r_per_cnt;
  logic [CntW-1:0] r_hi_cnt;
  logic [CntW-1:0] r_period;
  logic [CntW-1:0] r_high;
  logic            r_tick;
  logic            r_timeout;

  sync_edge u_sync (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_d     (SlowIn),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_level (w_level)
  );

  assign w_per_sat = (r_per_cnt == TO);
  assign w_per_inc = (&r_per_cnt) ? r_per_cnt : r_per_cnt + ONE;
  assign w_hi_inc  = (&r_hi_cnt) ? r_hi_cnt : r_hi_cnt + ONE;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else begin
      if (w_rise) begin
        r_per_cnt <= '0;
      end else if (!w_per_sat) begin
        r_per_cnt <= r_per_cnt + ONE;
      end
      if (w_rise) begin
        r_hi_cnt <= '0;
      end else if (w_level && (r_hi_cnt != TO)) begin
        r_hi_cnt <= r_hi_cnt + ONE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= WAIT_FIRST;
    else      r_state <= w_state_nxt;
  end

  // A rise on the saturation cycle beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_per   = 1'b0;
    w_cap_hi    = 1'b0;
    w_to_hit    = 1'b0;
    unique case (r_state)
      WAIT_FIRST: begin
        if (w_rise) w_state_nxt = MEASURE;
      end
      MEASURE, VALID: begin
        w_cap_hi = w_fall;
        if (w_rise) begin
          w_cap_per   = 1'b1;
          w_state_nxt = VALID;
        end else if (w_per_sat) begin
          w_to_hit    = 1'b1;
          w_state_nxt = WAIT_FIRST;
        end
      end
      default: w_state_nxt = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_tick    <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tick <= w_rise;
      if (w_cap_per) r_period <= w_per_inc;
      if (w_cap_hi)  r_high   <= w_hi_inc;
      if (w_rise)        r_timeout <= 1'b0;
      else if (w_to_hit) r_timeout <= 1'b1;
    end
  end

  assign Tick        = r_tick;
  assign Period      = r_period;
  assign HighTime    = r_high;
  assign PeriodValid = (r_state == VALID);
  assign Timeout     = r_timeout;

endmodule

// File: tb/tb_clk_edge_meter.sv
// Directed bench for clk_edge_meter with TimeoutVal=20.
// Edge numbers in notes count posedges after SlowIn is changed.
module tb_clk_edge_meter;
  import clk_edge_meter_pkg::*;

  localparam int W = 27;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         SlowIn = 1'b0;
  logic         Tick;
  logic [W-1:0] Period;
  logic [W-1:0] HighTime;
  logic         PeriodValid;
  logic         Timeout;

  int total = 0;
  int bad   = 0;
  int n_tick = 0;

  clk_edge_meter #(
    .TimeoutVal (20),
    .CntW       (W)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .SlowIn      (SlowIn),
    .Tick        (Tick),
    .Period      (Period),
    .HighTime    (HighTime),
    .PeriodValid (PeriodValid),
    .Timeout     (Timeout)
  );

  always #5 Clk = ~Clk;

  // Counts Tick-high cycles; a wide pulse inflates this count.
  always @(negedge Clk) if (Tick === 1'b1) n_tick++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drive(input int h, input int l);
    SlowIn = 1'b1;
    cyc(h);
    SlowIn = 1'b0;
    cyc(l);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"}, 32'(Tick), 0);
    chk({tag, "_per"}, 32'(Period), 0);
    chk({tag, "_hi"}, 32'(HighTime), 0);
    chk({tag, "_pv"}, 32'(PeriodValid), 0);
    chk({tag, "_to"}, 32'(Timeout), 0);
  endtask

  initial begin
    cyc(3);
    chk_zero("rst");
    Rst = 1'b1;
    cyc(4);

    // first rise: Tick only on the 3rd edge, arms MEASURE
    SlowIn = 1'b1;
    cyc(2);
    chk("lat_tick_lo", 32'(Tick), 0);
    cyc(1);
    chk("lat_tick_hi", 32'(Tick), 1);
    chk("first_pv", 32'(PeriodValid), 0);
    chk("first_per", 32'(Period), 0);
    cyc(1);
    chk("lat_tick_end", 32'(Tick), 0);
    cyc(1);
    SlowIn = 1'b0;
    cyc(5);
    drive(5, 5);
    drive(5, 5);
    chk("sq55_per", 32'(Period), 10);
    chk("sq55_hi", 32'(HighTime), 5);
    chk("sq55_pv", 32'(PeriodValid), 1);
    chk("sq55_ticks", 32'(n_tick), 3);

    // divider-like 4/4 wave
    drive(4, 4);
    drive(4, 4);
    drive(4, 4);
    chk("div_per", 32'(Period), 8);
    chk("div_hi", 32'(HighTime), 4);
    chk("div_to", 32'(Timeout), 0);
    chk("div_ticks", 32'(n_tick), 6);

    // last rise R at edge 3 of final drive; now R+5
    cyc(15);
    chk("pre_to", 32'(Timeout), 0);
    chk("pre_to_pv", 32'(PeriodValid), 1);
    cyc(1);
    chk("to_set", 32'(Timeout), 1);
    chk("to_pv", 32'(PeriodValid), 0);
    chk("to_per_kept", 32'(Period), 8);
    chk("to_hi_kept", 32'(HighTime), 4);
    cyc(10);
    chk("to_hold", 32'(Timeout), 1);
    chk("to_hold_pv", 32'(PeriodValid), 0);

    // restart after timeout
    SlowIn = 1'b1;
    cyc(2);
    chk("rearm_pre_tick", 32'(Tick), 0);
    chk("rearm_pre_to", 32'(Timeout), 1);
    cyc(1);
    chk("rearm_tick", 32'(Tick), 1);
    chk("rearm_to_clr", 32'(Timeout), 0);
    chk("rearm_state", 32'(dut.r_state), 32'(MEASURE));
    chk("rearm_per", 32'(Period), 8);

    // next rise lands on the saturation cycle: period 21
    cyc(2);
    SlowIn = 1'b0;
    cyc(16);
    SlowIn = 1'b1;
    cyc(2);
    chk("sat_no_to", 32'(Timeout), 0);
    cyc(1);
    chk("sat_tick", 32'(Tick), 1);
    chk("sat_per", 32'(Period), 21);
    chk("sat_hi", 32'(HighTime), 5);
    chk("sat_to", 32'(Timeout), 0);
    chk("sat_pv", 32'(PeriodValid), 1);

    // one-cycle high pulse
    cyc(2);
    SlowIn = 1'b0;
    cyc(6);
    SlowIn = 1'b1;
    cyc(1);
    SlowIn = 1'b0;
    cyc(5);
    chk("pulse_hi", 32'(HighTime), 1);
    chk("pulse_per", 32'(Period), 11);
    chk("pulse_ticks", 32'(n_tick), 9);

    // async reset mid high phase
    SlowIn = 1'b1;
    cyc(4);
    chk("mid_ticks", 32'(n_tick), 10);
    #2;
    Rst = 1'b0;
    #1;
    chk_zero("async");
    cyc(3);
    Rst = 1'b1;
    cyc(10);
    chk("held_ticks", 32'(n_tick), 10);
    chk("held_state", 32'(dut.r_state), 32'(WAIT_FIRST));
    SlowIn = 1'b0;
    cyc(5);
    SlowIn = 1'b1;
    cyc(2);
    chk("post_pre_tick", 32'(Tick), 0);
    cyc(1);
    chk("post_tick", 32'(Tick), 1);
    chk("post_pv", 32'(PeriodValid), 0);
    chk("post_per", 32'(Period), 0);
    chk("post_hi", 32'(HighTime), 0);
    chk("post_state", 32'(dut.r_state), 32'(MEASURE));
    cyc(2);
    chk("post_ticks", 32'(n_tick), 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
